// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings and constants for the multi-cycle fetch/decode/execute/writeback sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_REQ  = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXEC       = 3'd3,
        ST_WB         = 3'd4,
        ST_HALT       = 3'd5
    } state_e;

    localparam logic [6:0]  OPC_SYSTEM       = 7'b1110011;
    localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    // ebreak is the one SYSTEM encoding the sequencer itself acts on.
    function automatic logic is_ebreak(input logic [31:0] inst);
        return (inst[6:0] == OPC_SYSTEM) && (inst[31:7] == INST_EBREAK[31:7]);
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_unit.sv
// Architectural PC plus the staged next_pc, the +4 adder and the redirect alignment check.
module fetch_sequencer_pc_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_exec,   // execute finished: pick redirect target or pc+4
    input  logic            load_seq,    // illegal-as-NOP: sequential next_pc
    input  logic            commit,      // writeback: pc takes next_pc
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4   = pc_q + XLEN'(4);
    assign misaligned = redirect && (target[1:0] != 2'b00);
    assign pc         = pc_q;

    // Select the staged next_pc and commit it to pc only in writeback.
    always_comb begin
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        if (load_exec) begin
            next_pc_d = redirect ? target : pc_plus4;
        end else if (load_seq) begin
            next_pc_d = pc_plus4;
        end
        if (commit) begin
            pc_d = next_pc_q;
        end
    end

    // PC registers, reset to the boot address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
        end else begin
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle control FSM: fetch into IR, decode, execute, writeback; halts on ebreak/illegal/misaligned.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_PC     = XLEN'(DEFAULT_RESET_PC),
    parameter bit              ILLEGAL_HALT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    input  logic            dec_valid,
    output logic            ex_start,
    input  logic            ex_done,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    output logic            wb_en,
    output logic [XLEN-1:0] pc,
    output logic [63:0]     retired,
    output logic            halt,
    output logic            illegal
);

    // Fetch handshake: imem_req stays high in FETCH_REQ until a cycle with imem_gnt=1
    // (request accepted on that edge); the response is the first cycle with imem_rvalid=1
    // while in FETCH_WAIT. rvalid seen in any other state is not ours and is ignored.

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [63:0] retired_q, retired_d;
    logic        ex_start_q, ex_start_d;
    logic        wb_en_q, wb_en_d;
    logic        halt_q, halt_d;
    logic        illegal_q, illegal_d;
    logic        load_exec, load_seq, commit;
    logic        misaligned;

    fetch_sequencer_pc_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_exec  (load_exec),
        .load_seq   (load_seq),
        .commit     (commit),
        .redirect   (ex_redirect),
        .target     (ex_target),
        .pc         (pc),
        .misaligned (misaligned)
    );

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        retired_d  = retired_q;
        ex_start_d = 1'b0;
        wb_en_d    = 1'b0;
        halt_d     = halt_q;
        illegal_d  = illegal_q;
        load_exec  = 1'b0;
        load_seq   = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_FETCH_REQ: begin
                if (imem_gnt) state_d = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                if (imem_rvalid) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_ebreak(ir_q)) begin
                    state_d   = ST_HALT;
                    halt_d    = 1'b1;
                    retired_d = retired_q + 64'd1;
                end else if (!dec_valid) begin
                    if (ILLEGAL_HALT) begin
                        state_d   = ST_HALT;
                        halt_d    = 1'b1;
                        illegal_d = 1'b1;
                    end else begin
                        // Retire as a NOP: advance pc, no register write.
                        state_d  = ST_WB;
                        load_seq = 1'b1;
                    end
                end else begin
                    state_d    = ST_EXEC;
                    ex_start_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (ex_done) begin
                    load_exec = 1'b1;
                    if (misaligned) begin
                        state_d   = ST_HALT;
                        halt_d    = 1'b1;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = ST_WB;
                        wb_en_d = 1'b1;
                    end
                end
            end
            ST_WB: begin
                commit    = 1'b1;
                retired_d = retired_q + 64'd1;
                state_d   = ST_FETCH_REQ;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH_REQ;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH_REQ;
            ir_q       <= INST_NOP;
            retired_q  <= 64'd0;
            ex_start_q <= 1'b0;
            wb_en_q    <= 1'b0;
            halt_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            retired_q  <= retired_d;
            ex_start_q <= ex_start_d;
            wb_en_q    <= wb_en_d;
            halt_q     <= halt_d;
            illegal_q  <= illegal_d;
        end
    end

    assign imem_req  = (state_q == ST_FETCH_REQ);
    assign imem_addr = pc;
    assign ir        = ir_q;
    assign ex_start  = ex_start_q;
    assign wb_en     = wb_en_q;
    assign retired   = retired_q;
    assign halt      = halt_q;
    assign illegal   = illegal_q;

endmodule
